vec_data_mem_dump: RTL and testbench

- Parametrised successor of the vector data memory: D words, each R lanes of N bits.
- Adds per-lane write masking, a registered read port, and a dump engine.
- The dump engine streams a word range out lane-by-lane over a valid/ready port to the interpreter link, with a Stall output that freezes the CPU.
- Sits beside cpu in top: CPU port on the memory side, stream port toward the interpreter communication block.

---
 rtl/vec_data_mem_dump_if.sv | 41 ++++
 rtl/vec_data_mem_dump.sv | 155 +++++++++++++++
 tb/tb_vec_data_mem_dump.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/vec_data_mem_dump_if.sv
// CPU memory port and dump stream port of the vector data memory.
// Master drives the CPU/stream-sink side; slave is the memory itself.
interface vec_data_mem_dump_if #(
  parameter int N = 8,
  parameter int R = 6,
  parameter int D = 256,
  parameter int I = 32
);
  localparam int AW = $clog2(D);

  logic                WE;
  logic [I-1:0]        A;
  logic [R-1:0][N-1:0] WD;
  logic [R-1:0]        LaneMask;
  logic [R-1:0][N-1:0] RD;
  logic                DumpStart;
  logic [AW-1:0]       DumpBase;
  logic [AW:0]         DumpLen;
  logic                DumpBusy;
  logic                Stall;
  logic                OutValid;
  logic                OutReady;
  logic [N-1:0]        OutData;
  logic                OutLast;

  modport master (
    output WE, A, WD, LaneMask,
    output DumpStart, DumpBase, DumpLen,
    output OutReady,
    input  RD, DumpBusy, Stall,
    input  OutValid, OutData, OutLast
  );

  modport slave (
    input  WE, A, WD, LaneMask,
    input  DumpStart, DumpBase, DumpLen,
    input  OutReady,
    output RD, DumpBusy, Stall,
    output OutValid, OutData, OutLast
  );
endinterface

// File: rtl/vec_data_mem_dump.sv
// Lane-masked vector data memory with registered read and a stream dump engine.
// Define DUMP_CHECKSUM_EN to append an XOR checksum beat to every dump.
module vec_data_mem_dump #(
  parameter int N = 8,
  parameter int R = 6,
  parameter int D = 256,
  parameter int I = 32
) (
  input  logic                clk,
  input  logic                reset,
  vec_data_mem_dump_if.slave  bus
);
  localparam int AW = $clog2(D);
  localparam int LW = (R > 1) ? $clog2(R) : 1;
  localparam logic [LW-1:0] LMAX = LW'(R - 1);
  localparam logic [I-1:0] DEPTH = I'(D);

`ifdef DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {
    IDLE, FETCH, SEND, DONE, CSUM
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, FETCH, SEND, DONE
  } state_t;
`endif

  logic [R-1:0][N-1:0] mem [D];
  logic [R-1:0][N-1:0] wbuf;
  logic [R-1:0][N-1:0] rd_q;

  state_t        state, state_n;
  logic [AW-1:0] ptr, ptr_n;
  logic [AW:0]   rem, rem_n;
  logic [LW-1:0] lane, lane_n;
  logic          busy, in_range, last_beat;
  logic [AW-1:0] addr;
  logic          out_valid, out_last;
  logic [N-1:0]  out_data;
`ifdef DUMP_CHECKSUM_EN
  logic [N-1:0]  acc, acc_n;
`endif

  assign addr     = bus.A[AW-1:0];
  assign in_range = bus.A < DEPTH;
  assign busy     = state != IDLE;

  assign bus.DumpBusy = busy;
  assign bus.Stall    = busy;
  assign bus.OutValid = out_valid;
  assign bus.OutData  = out_data;
  assign bus.OutLast  = out_last;
  assign bus.RD       = rd_q;

  // Array and fetch buffer carry no reset so they map onto RAM.
  always_ff @(posedge clk) begin
    if (bus.WE && !busy && in_range) begin
      for (int k = 0; k < R; k++) begin
        if (bus.LaneMask[k]) mem[addr][k] <= bus.WD[k];
      end
    end
    if (state == FETCH) wbuf <= mem[ptr];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rd_q <= '0;
    else        rd_q <= in_range ? mem[addr] : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      rem   <= '0;
      lane  <= '0;
`ifdef DUMP_CHECKSUM_EN
      acc   <= '0;
`endif
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
      rem   <= rem_n;
      lane  <= lane_n;
`ifdef DUMP_CHECKSUM_EN
      acc   <= acc_n;
`endif
    end
  end

  always_comb begin
    state_n   = state;
    ptr_n     = ptr;
    rem_n     = rem;
    lane_n    = lane;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    last_beat = (rem == (AW+1)'(1)) && (lane == LMAX);
`ifdef DUMP_CHECKSUM_EN
    acc_n     = acc;
`endif
    unique case (state)
      IDLE: begin
        if (bus.DumpStart && bus.DumpLen != '0) begin
          ptr_n   = bus.DumpBase;
          rem_n   = bus.DumpLen;
          lane_n  = '0;
          state_n = FETCH;
`ifdef DUMP_CHECKSUM_EN
          acc_n   = '0;
`endif
        end
      end
      FETCH: state_n = SEND;
      SEND: begin
        out_valid = 1'b1;
        out_data  = wbuf[lane];
`ifdef DUMP_CHECKSUM_EN
        out_last  = 1'b0;
`else
        out_last  = last_beat;
`endif
        if (bus.OutReady) begin
`ifdef DUMP_CHECKSUM_EN
          acc_n = acc ^ out_data;
`endif
          if (lane != LMAX) begin
            lane_n = lane + LW'(1);
          end else if (!last_beat) begin
            rem_n   = rem - (AW+1)'(1);
            ptr_n   = ptr + AW'(1);
            lane_n  = '0;
            state_n = FETCH;
          end else begin
`ifdef DUMP_CHECKSUM_EN
            state_n = CSUM;
`else
            state_n = DONE;
`endif
          end
        end
      end
`ifdef DUMP_CHECKSUM_EN
      CSUM: begin
        out_valid = 1'b1;
        out_data  = acc;
        out_last  = 1'b1;
        if (bus.OutReady) state_n = DONE;
      end
`endif
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_vec_data_mem_dump.sv
// Directed self-checking bench for vec_data_mem_dump.
// Covers masked writes, read latency, range decode and the dump stream.
module tb_vec_data_mem_dump;
  logic clk;
  logic rst_n;
  int   checks = 0;
  int   passes = 0;
  logic [7:0] mdl [256][6];
  logic [7:0] last_data;

  vec_data_mem_dump_if #(.N(8), .R(6), .D(256), .I(32)) bus ();

  vec_data_mem_dump #(.N(8), .R(6), .D(256), .I(32)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [47:0] mword(input int a);
    logic [47:0] r;
    for (int k = 0; k < 6; k++) r[k*8 +: 8] = mdl[a][k];
    return r;
  endfunction

  task automatic wr(input int a, input logic [47:0] wd, input logic [5:0] m);
    bus.WE       = 1'b1;
    bus.A        = a;
    bus.WD       = wd;
    bus.LaneMask = m;
    tick();
    bus.WE = 1'b0;
    if (a < 256) begin
      for (int k = 0; k < 6; k++)
        if (m[k]) mdl[a][k] = wd[k*8 +: 8];
    end
  endtask

  task automatic run_dump(input int base, input int len,
                          input bit toggle, input bit disturb);
    int total, nb, cyc, w, k;
    logic [7:0] exp_d, x, pd;
    logic exp_l, pl;
    bit stl;
    total = 6 * len;
`ifdef DUMP_CHECKSUM_EN
    total++;
`endif
    x = '0; nb = 0; cyc = 0; stl = 0; pd = '0; pl = 1'b0;
    bus.DumpBase  = base[7:0];
    bus.DumpLen   = len[8:0];
    bus.DumpStart = 1'b1;
    bus.OutReady  = 1'b1;
    tick();
    bus.DumpStart = 1'b0;
    while (nb < total && cyc < 400) begin
      bus.OutReady = toggle ? cyc[0] : 1'b1;
      if (disturb && cyc == 3) begin
        bus.WE        = 1'b1;
        bus.A         = base;
        bus.WD        = '0;
        bus.LaneMask  = '1;
        bus.DumpStart = 1'b1;
        bus.DumpBase  = 8'd100;
        bus.DumpLen   = 9'd4;
      end else begin
        bus.WE        = 1'b0;
        bus.DumpStart = 1'b0;
      end
      if (stl) begin
        chk("hold_valid", bus.OutValid, 1);
        chk("hold_data", bus.OutData, pd);
        chk("hold_last", bus.OutLast, pl);
      end
      if (bus.OutValid && bus.OutReady) begin
        w = nb / 6;
        k = nb % 6;
        if (nb < 6 * len) begin
          exp_d = mdl[(base + w) % 256][k];
          x     = x ^ exp_d;
          exp_l = (nb == total - 1);
        end else begin
          exp_d = x;
          exp_l = 1'b1;
        end
        chk("beat_data", bus.OutData, exp_d);
        chk("beat_last", bus.OutLast, exp_l);
        last_data = bus.OutData;
        nb++;
      end
      stl = bus.OutValid && !bus.OutReady;
      pd  = bus.OutData;
      pl  = bus.OutLast;
      tick();
      cyc++;
    end
    bus.WE        = 1'b0;
    bus.DumpStart = 1'b0;
    bus.OutReady  = 1'b1;
    chk("beat_count", nb, total);
    chk("done_busy", bus.DumpBusy, 1);
    chk("done_valid", bus.OutValid, 0);
    tick();
    chk("idle_busy", bus.DumpBusy, 0);
    chk("idle_stall", bus.Stall, 0);
  endtask

  initial begin
    int nb, cyc;
    logic [47:0] wd;
    for (int a = 0; a < 256; a++)
      for (int k = 0; k < 6; k++) mdl[a][k] = '0;
    last_data     = '0;
    rst_n         = 1'b0;
    bus.WE        = 1'b0;
    bus.A         = '0;
    bus.WD        = '0;
    bus.LaneMask  = '0;
    bus.DumpStart = 1'b0;
    bus.DumpBase  = '0;
    bus.DumpLen   = '0;
    bus.OutReady  = 1'b0;
    #1;
    chk("rst_rd", bus.RD, 0);
    chk("rst_valid", bus.OutValid, 0);
    chk("rst_data", bus.OutData, 0);
    chk("rst_last", bus.OutLast, 0);
    chk("rst_busy", bus.DumpBusy, 0);
    chk("rst_stall", bus.Stall, 0);
    #2 rst_n = 1'b1;
    tick();

    wr(5, {8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, 6'b111111);
    bus.A = 5;
    tick();
    chk("rd_full", bus.RD, 48'h66_55_44_33_22_11);
    wr(5, {6{8'hFF}}, 6'b000101);
    tick();
    chk("rd_masked", bus.RD, 48'h66_55_44_FF_22_FF);

    wr(7, '0, 6'b111111);
    bus.WE       = 1'b1;
    bus.A        = 7;
    bus.WD       = {6{8'hAA}};
    bus.LaneMask = 6'b111111;
    tick();
    chk("raw_old", bus.RD, 0);
    bus.WE = 1'b0;
    for (int k = 0; k < 6; k++) mdl[7][k] = 8'hAA;
    tick();
    chk("raw_new", bus.RD, {6{8'hAA}});

    wr(44, {6{8'h12}}, 6'b111111);
    wr(300, {6{8'h5A}}, 6'b111111);
    bus.A = 300;
    tick();
    chk("oor_read", bus.RD, 0);
    bus.A = 44;
    tick();
    chk("oor_alias", bus.RD, {6{8'h12}});

    for (int k = 0; k < 6; k++) wd[k*8 +: 8] = 8'hA0 + 8'(k);
    wr(254, wd, 6'b111111);
    for (int k = 0; k < 6; k++) wd[k*8 +: 8] = 8'hB0 + 8'(k);
    wr(255, wd, 6'b111111);
    for (int k = 0; k < 6; k++) wd[k*8 +: 8] = 8'hC0 + 8'(k);
    wr(0, wd, 6'b111111);
    for (int k = 0; k < 6; k++) wd[k*8 +: 8] = 8'h60 + 8'(k);
    wr(6, wd, 6'b111111);

    run_dump(254, 3, 1'b0, 1'b0);
    chk("w254_lane0", mdl[254][0], 8'hA0);

    run_dump(5, 2, 1'b1, 1'b1);
    bus.A = 5;
    tick();
    tick();
    chk("busy_write_drop", bus.RD, 48'h66_55_44_FF_22_FF);

    bus.DumpBase  = 8'd3;
    bus.DumpLen   = '0;
    bus.DumpStart = 1'b1;
    tick();
    bus.DumpStart = 1'b0;
    chk("len0_busy", bus.DumpBusy, 0);
    tick();
    chk("len0_valid", bus.OutValid, 0);

    bus.DumpBase  = 8'd254;
    bus.DumpLen   = 9'd3;
    bus.DumpStart = 1'b1;
    bus.OutReady  = 1'b1;
    tick();
    bus.DumpStart = 1'b0;
    nb  = 0;
    cyc = 0;
    while (nb < 4 && cyc < 50) begin
      if (bus.OutValid) nb++;
      tick();
      cyc++;
    end
    chk("rst_pre_count", nb, 4);
    chk("rst_pre_valid", bus.OutValid, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", bus.OutValid, 0);
    chk("rst_mid_busy", bus.DumpBusy, 0);
    chk("rst_mid_stall", bus.Stall, 0);
    #1 rst_n = 1'b1;
    tick();
    tick();
    chk("rst_no_resume", bus.DumpBusy, 0);

`ifdef DUMP_CHECKSUM_EN
    wr(9, {8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01}, 6'b111111);
    run_dump(9, 1, 1'b0, 1'b0);
    chk("csum_value", last_data, 8'h3F);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
